// File: rtl/vmicro16_apb_pkg.sv
// Shared definitions for the vmicro16 APB arbiter.
//   APB_WIDTH_DEFAULT : default address/data width of the APB fabric
//   apb_state_t       : arbiter FSM states (IDLE, SETUP, ACCESS, RESP)
package vmicro16_apb_pkg;

    localparam int APB_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

endpackage

// File: rtl/vmicro16_rr_arbiter.sv
// Round-robin grant selector.
//   req   : per-master request vector
//   last  : index of the most recently granted master
//   grant : one-hot grant, first requester strictly after 'last' (wrapping),
//           all zero when nobody requests
module vmicro16_rr_arbiter #(
    parameter int MASTERS = 2,
    parameter int LW      = 1
) (
    input  logic [MASTERS-1:0] req,
    input  logic [LW-1:0]      last,
    output logic [MASTERS-1:0] grant
);

    int unsigned tgt;
    logic        found;

    // Walk the candidates in priority order last+1 .. last+MASTERS (mod
    // MASTERS); the inner loop keeps every bit-select index constant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        tgt   = '0;
        for (int unsigned off = 1; off <= MASTERS; off++) begin
            tgt = 32'(last) + off;
            if (tgt >= MASTERS) begin
                tgt = tgt - MASTERS;
            end
            for (int unsigned m = 0; m < MASTERS; m++) begin
                if (!found && (m == tgt) && req[m]) begin
                    grant[m] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// Multi-master to single-bus APB arbiter.
//   clk, reset             : clock (rising edge), asynchronous active-low reset
//   S_PADDR/S_PWDATA       : per-master address / write data (master i at i*APB_WIDTH)
//   S_PWRITE/S_PSELx       : per-master direction / request
//   S_PENABLE              : per-master enable (not needed to arbitrate)
//   S_PRDATA/S_PREADY/S_PSLVERR : per-master response, valid for one RESP cycle
//   M_PADDR/M_PWDATA/M_PWRITE   : registered shared-bus request
//   M_PSELx/M_PENABLE      : one-hot slave select / APB enable phase
//   M_PRDATA/M_PREADY/M_PSLVERR : shared-bus response
module vmicro16_apb_arbiter
    import vmicro16_apb_pkg::*;
#(
    parameter int MASTERS   = 2,
    parameter int SLAVES    = 5,
    parameter int APB_WIDTH = APB_WIDTH_DEFAULT,
    parameter int SEL_LSB   = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MASTERS*APB_WIDTH-1:0] S_PADDR,
    input  logic [MASTERS*APB_WIDTH-1:0] S_PWDATA,
    input  logic [MASTERS-1:0]           S_PWRITE,
    input  logic [MASTERS-1:0]           S_PSELx,
    input  logic [MASTERS-1:0]           S_PENABLE,
    output logic [MASTERS*APB_WIDTH-1:0] S_PRDATA,
    output logic [MASTERS-1:0]           S_PREADY,
    output logic [MASTERS-1:0]           S_PSLVERR,
    output logic [APB_WIDTH-1:0]         M_PADDR,
    output logic [APB_WIDTH-1:0]         M_PWDATA,
    output logic                         M_PWRITE,
    output logic                         M_PENABLE,
    output logic [SLAVES-1:0]            M_PSELx,
    input  logic [APB_WIDTH-1:0]         M_PRDATA,
    input  logic                         M_PREADY,
    input  logic                         M_PSLVERR
);

    localparam int LW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          TMO_EN   = (TIMEOUT > 0);

    apb_state_t state, state_next;

    logic [MASTERS-1:0]   grant;
    logic [LW-1:0]        grant_idx, gnt_idx, last;
    logic [APB_WIDTH-1:0] req_addr, req_wdata, dec_idx, rdata_q;
    logic                 req_write, dec_valid, err_q, timed_out;
    logic [SLAVES-1:0]    dec_sel, sel_q;
    logic [CW-1:0]        cnt;
    logic                 unused_penable;

    assign unused_penable = ^S_PENABLE;

    vmicro16_rr_arbiter #(
        .MASTERS (MASTERS),
        .LW      (LW)
    ) u_rr (
        .req   (S_PSELx),
        .last  (last),
        .grant (grant)
    );

    // Mux the granted master's request and decode its target slave.
    always_comb begin
        grant_idx = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if (grant[m]) begin
                grant_idx = LW'(m);
                req_addr  = S_PADDR[m*APB_WIDTH +: APB_WIDTH];
                req_wdata = S_PWDATA[m*APB_WIDTH +: APB_WIDTH];
                req_write = S_PWRITE[m];
            end
        end
        dec_idx   = req_addr >> SEL_LSB;
        dec_valid = (dec_idx < APB_WIDTH'(SLAVES));
        dec_sel   = '0;
        for (int unsigned s = 0; s < SLAVES; s++) begin
            dec_sel[s] = (dec_idx == APB_WIDTH'(s));
        end
    end

    assign timed_out = TMO_EN && (cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|S_PSELx) state_next = dec_valid ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (M_PREADY || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch at grant, response capture in ACCESS. An undecodable
    // address pre-loads the error response so RESP follows IDLE directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last     <= LW'(MASTERS - 1);
            gnt_idx  <= '0;
            M_PADDR  <= '0;
            M_PWDATA <= '0;
            M_PWRITE <= 1'b0;
            sel_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|S_PSELx) begin
                        gnt_idx  <= grant_idx;
                        last     <= grant_idx;
                        M_PADDR  <= req_addr;
                        M_PWDATA <= req_wdata;
                        M_PWRITE <= req_write;
                        sel_q    <= dec_valid ? dec_sel : '0;
                        rdata_q  <= '0;
                        err_q    <= !dec_valid;
                    end
                end
                SETUP: cnt <= '0;
                ACCESS: begin
                    if (M_PREADY) begin
                        rdata_q <= M_PRDATA;
                        err_q   <= M_PSLVERR;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        M_PSELx   = ((state == SETUP) || (state == ACCESS)) ? sel_q : '0;
        M_PENABLE = (state == ACCESS);
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if ((state == RESP) && (gnt_idx == LW'(m))) begin
                S_PREADY[m]                          = 1'b1;
                S_PSLVERR[m]                         = err_q;
                S_PRDATA[m*APB_WIDTH +: APB_WIDTH]   = rdata_q;
            end
        end
    end

endmodule

// File: doc/vmicro16_apb_arbiter.md
VMICRO16_APB_ARBITER -- requirements
Module: vmicro16_apb_arbiter

Interface
REQ-001 SHALL have parameter MASTERS, default 2, number of APB master ports.
REQ-002 SHALL have parameter SLAVES, default 5, number of APB slave selects.
REQ-003 SHALL have parameter APB_WIDTH, default 16, address and data width.
REQ-004 SHALL have parameter SEL_LSB, default 8; slave index = PADDR >> SEL_LSB.
REQ-005 SHALL have parameter TIMEOUT, default 255, max ACCESS cycles before forced error (0 disables).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports S_PADDR/S_PWDATA, input, MASTERS*APB_WIDTH, per-master address/write data, master i at [i*APB_WIDTH +: APB_WIDTH].
REQ-009 SHALL have ports S_PWRITE/S_PSELx/S_PENABLE, input, MASTERS, per-master controls.
REQ-010 SHALL have port S_PRDATA, output, MASTERS*APB_WIDTH, per-master read data.
REQ-011 SHALL have ports S_PREADY/S_PSLVERR, output, MASTERS, per-master completion/error.
REQ-012 SHALL have ports M_PADDR/M_PWDATA, output, APB_WIDTH; M_PWRITE/M_PENABLE, output, 1; M_PSELx, output, SLAVES (one-hot).
REQ-013 SHALL have ports M_PRDATA, input, APB_WIDTH, and M_PREADY/M_PSLVERR, input, 1, from the shared slave bus.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-015 A master requests when S_PSELx[i]=1; it holds PADDR/PWRITE/PWDATA stable until its S_PREADY=1.
REQ-016 IDLE with >=1 request SHALL grant one master round-robin, latch its address/data/write, and go to SETUP next cycle.
REQ-017 Round-robin SHALL pick the first requester strictly after the last-granted index, wrapping MASTERS-1 -> 0.
REQ-018 SETUP SHALL drive M_PSELx one-hot to decoded slave, M_PENABLE=0, then go to ACCESS.
REQ-019 ACCESS SHALL drive M_PENABLE=1 and hold M_PSELx; on M_PREADY=1, capture M_PRDATA and M_PSLVERR and go to RESP.
REQ-020 RESP SHALL assert S_PREADY for the granted master only, for exactly one cycle, with captured S_PRDATA/S_PSLVERR; then go to IDLE.
REQ-021 Non-granted masters SHALL see S_PREADY=0, S_PSLVERR=0, S_PRDATA=0.
REQ-022 Minimum latency request-to-S_PREADY with zero-wait slave SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP).
REQ-023 Decoded index >= SLAVES SHALL skip SETUP/ACCESS, assert no M_PSELx, and go IDLE -> RESP with S_PSLVERR=1, S_PRDATA=0.
REQ-024 ACCESS counter SHALL reach TIMEOUT without M_PREADY -> go to RESP with S_PSLVERR=1, S_PRDATA=0, M_PSELx/M_PENABLE dropped.
REQ-025 Requests arriving mid-transfer SHALL wait; the requesting master's S_PSELx deassertion before grant SHALL cancel it without side effects.
REQ-026 Simultaneous requests from all masters SHALL each be served once per MASTERS transfers (no starvation).
REQ-027 M_PADDR/M_PWDATA/M_PWRITE SHALL be registered and stable from SETUP through ACCESS.

Reset
REQ-028 reset=0 SHALL asynchronously force state IDLE, all outputs 0, timeout counter 0.
REQ-029 reset SHALL set last-granted index to MASTERS-1 so master 0 wins first.
REQ-030 reset asserted mid-transfer SHALL abort it; no S_PREADY is issued for the aborted transfer.

Structure
REQ-031 State encodings and APB_WIDTH default SHALL live in shared package vmicro16_apb_pkg.
REQ-032 Round-robin grant logic SHALL be sub-module vmicro16_rr_arbiter (inputs req, last; output one-hot grant).

Verification
REQ-033 Single master 0 writes 0xBEEF to 0x0310, zero-wait slave -> M_PSELx=5'b01000 in SETUP/ACCESS, S_PREADY[0] on cycle 4, S_PSLVERR=0.
REQ-034 Masters 0 and 1 request same cycle after reset -> master 0 served first, master 1 second; next simultaneous pair -> master 0 again after 1.
REQ-035 Read 0x0400 from slave returning 0x1234 after 3 wait states -> S_PRDATA[1]=0x1234, S_PREADY 7 cycles after request.
REQ-036 Address 0x0700 (index 7 >= 5) -> no M_PSELx asserted, S_PSLVERR=1 with S_PREADY 2 cycles after request.
REQ-037 TIMEOUT=4, slave never ready -> M_PENABLE drops after 4 ACCESS cycles, S_PSLVERR=1.
REQ-038 reset=0 during ACCESS -> all outputs 0 same cycle, no S_PREADY; pending request re-served from master 0 after release.
